sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter that shares one single-port 256x8 SRAM macro between the labeling datapath (port 0) and a readback/configuration client (port 1). It issues at most one SRAM access per cycle and grants bounded-fairness "sticky" ownership so neither port starves. It returns read data with the macro's one-cycle latency, tagged to the requester that issued the read. It sits between the label-engine control FSM / host logic and the `sram_256x8` instance, and drives the macro's CEN/WEN/A/D pins.

## Interface
- `AW`, 8: SRAM address width.
- `DW`, 8: SRAM data width.
- `MAX_HOLD`, 4: maximum consecutive grants to one port while the other port is requesting (legal range 1..15).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `r0_req`  in  1  port 0 access request; held until granted.
- `r0_wen`  in  1  port 0 write enable, active-low (0 = write, 1 = read).
- `r0_a`  in  AW  port 0 address.
- `r0_d`  in  DW  port 0 write data.
- `r0_gnt`  out  1  port 0 granted this cycle.
- `r0_rvalid`  out  1  `rdata` holds port 0 read result.
- `r1_req`, `r1_wen`, `r1_a`, `r1_d`, `r1_gnt`, `r1_rvalid`: same as port 0, for port 1.
- `rdata`  out  DW  read data, valid only when an `rN_rvalid` is high.
- `mem_cen`  out  1  SRAM chip enable, active-low.
- `mem_wen`  out  1  SRAM write enable, active-low.
- `mem_a`  out  AW  SRAM address.
- `mem_d`  out  DW  SRAM write data.
- `mem_q`  in  DW  SRAM read data, valid one cycle after the read was issued.

## Operation
- Registered state:
  - `owner` (1 bit): last granted port.
  - `hold` (4 bits, saturating): consecutive grants to `owner`.
  - `rd_pend` (1 bit) and `rd_tag` (1 bit): an outstanding read and the port that issued it.
- Grant decision (combinational from `rN_req` and the registered state):
  - Neither port requesting: no grant; `mem_cen`=1.
  - Only one port requesting: grant that port.
  - Both requesting, `owner` requesting and `hold` < `MAX_HOLD`: grant `owner`.
  - Both requesting, otherwise: grant the other port.
  - Exactly one `rN_gnt` is high per cycle, or none.
- Memory drive:
  - On a grant: `mem_cen`=0, and `mem_wen`/`mem_a`/`mem_d` are a mux of the winner's `rN_wen`/`rN_a`/`rN_d`.
  - No grant: `mem_cen`=1, `mem_wen`=1, `mem_a`=0, `mem_d`=0.
- State update on each rising edge:
  - Grant to the same port as `owner`: `hold` increments, saturating at 15.
  - Grant to the other port: `owner` switches to it and `hold`=1.
  - No grant: `owner` is kept and `hold`=0.
  - Granted read (`wen`=1): `rd_pend`=1 and `rd_tag` = winner. Otherwise `rd_pend`=0.
- Read return:
  - `r0_rvalid` = `rd_pend` & !`rd_tag`.
  - `r1_rvalid` = `rd_pend` & `rd_tag`.
  - `rdata` = `mem_q` when `rd_pend`=1, else 0.
- Write-then-read to the same address on consecutive cycles returns the new data, because the macro commits writes at the grant edge.
- Requester contract: a requester keeps `req`/`wen`/`a`/`d` stable until it sees `gnt`. The arbiter never buffers requests.

## Timing
- Reset (`reset`=0 at an edge) sets `owner`=0, `hold`=0, `rd_pend`=0, `rd_tag`=0.
- Output values while `reset` is low:
  - `r0_gnt`=0, `r1_gnt`=0, `r0_rvalid`=0, `r1_rvalid`=0.
  - `rdata`=0, `mem_cen`=1, `mem_wen`=1, `mem_a`=0, `mem_d`=0.
  - The grant logic is forced off.
- Reset mid-operation: an outstanding read's `rvalid` is dropped; no write is issued during a reset cycle.
- Latencies:
  - Grant: 0 cycles, same cycle as `req` when the port wins.
  - Write: committed at the edge ending the grant cycle.
  - Read: `rvalid` and `rdata` valid exactly 1 cycle after the grant cycle.
- Throughput: one access per cycle. Back-to-back reads from alternating ports return in issue order, each with its own tag.
- First tie after reset goes to port 0 (`owner`=0, `hold`=0 < `MAX_HOLD`).
- Fairness bound: a continuously requesting port waits at most `MAX_HOLD` cycles.
- `MAX_HOLD`=1 gives strict alternation under contention.

## Test plan
- Reset, then `r0` writes `0x5A` to `0x10` and the next cycle reads `0x10`: `r0_gnt`=1 in both cycles; `r0_rvalid`=1 with `rdata`=`0x5A` one cycle after the read grant; `r1_rvalid` stays 0.
- Both ports request reads continuously with `MAX_HOLD`=4: grant sequence is 0,0,0,0,1,1,1,1,0,… and each `rvalid` tag matches its issuing port.
- `r1` alone requests 3 cycles, then both request: `r1` holds for one more grant (`hold`=4), then `r0` wins; `hold` resets to 1.
- Idle cycle between requests: `hold` clears to 0, and the previous `owner` wins the next tie.
- Read granted, then `reset`=0 on the following edge: no `rvalid` is asserted, all outputs go to reset values, and the first tie after reset goes to port 0.
- Port 1 writes `0xFF` to `0x00` while port 0 reads `0x00` in the next cycle: port 0 receives `0xFF`.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port 256x8 SRAM macro.
// One access per cycle, sticky ownership bounded by MAX_HOLD under contention,
// read data returned one cycle after the grant and tagged to its requester.
module sram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_wen,
  input  logic [AW-1:0] r0_a,
  input  logic [DW-1:0] r0_d,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_wen,
  input  logic [AW-1:0] r1_a,
  input  logic [DW-1:0] r1_d,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  logic       owner;
  logic [3:0] hold;
  logic       rd_pend;
  logic       rd_tag;
  logic       gnt0;
  logic       gnt1;

  // Saturating increment of the consecutive-grant counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Grant decision: sole requester wins; on a tie the owner keeps the port
  // until it has used up its hold budget. Forced off while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (r0_req && r1_req) begin
        if (hold < HOLD_LIMIT) begin
          gnt0 = !owner;
          gnt1 = owner;
        end else begin
          gnt0 = owner;
          gnt1 = !owner;
        end
      end else begin
        gnt0 = r0_req;
        gnt1 = r1_req;
      end
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  // Memory pin mux: winner's command, or an idle, deselected macro.
  always_comb begin
    mem_cen = 1'b1;
    mem_wen = 1'b1;
    mem_a   = '0;
    mem_d   = '0;
    if (gnt0) begin
      mem_cen = 1'b0;
      mem_wen = r0_wen;
      mem_a   = r0_a;
      mem_d   = r0_d;
    end else if (gnt1) begin
      mem_cen = 1'b0;
      mem_wen = r1_wen;
      mem_a   = r1_a;
      mem_d   = r1_d;
    end
  end

  // Ownership/hold tracking and the outstanding-read tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner   <= 1'b0;
      hold    <= 4'd0;
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else if (gnt0 || gnt1) begin
      if (gnt1 == owner) begin
        hold <= sat_inc(hold);
      end else begin
        owner <= gnt1;
        hold  <= 4'd1;
      end
      rd_pend <= mem_wen;
      if (mem_wen) begin
        rd_tag <= gnt1;
      end
    end else begin
      hold    <= 4'd0;
      rd_pend <= 1'b0;
    end
  end

  // Read return, one cycle after the read grant; suppressed during reset.
  assign r0_rvalid = reset & rd_pend & ~rd_tag;
  assign r1_rvalid = reset & rd_pend & rd_tag;
  assign rdata     = (reset && rd_pend) ? mem_q : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 256x8 SRAM model.
module tb_sram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       r0_req, r0_wen, r0_gnt, r0_rvalid;
  logic [7:0] r0_a, r0_d;
  logic       r1_req, r1_wen, r1_gnt, r1_rvalid;
  logic [7:0] r1_a, r1_d;
  logic [7:0] rdata;
  logic       mem_cen, mem_wen;
  logic [7:0] mem_a, mem_d, mem_q;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(8), .DW(8), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_wen(r0_wen), .r0_a(r0_a), .r0_d(r0_d),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_wen(r1_wen), .r1_a(r1_a), .r1_d(r1_d),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q)
  );

  // SRAM macro model: write commits at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) mem[mem_a] <= mem_d;
      else          mem_q <= mem[mem_a];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic q0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic q1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    r0_req = q0; r0_wen = w0; r0_a = a0; r0_d = d0;
    r1_req = q1; r1_wen = w1; r1_a = a1; r1_d = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1, 0, 8'h33, 8'h44, 1, 0, 8'h55, 8'h66);
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", {r1_gnt, r0_gnt}); end
    checks++; if ({r1_rvalid, r0_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {r1_rvalid, r0_rvalid}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    checks++; if ({mem_cen, mem_wen} !== 2'b11) begin errors++; $display("FAIL reset_cen_wen: got %b want 11", {mem_cen, mem_wen}); end
    checks++; if (mem_a !== 8'h00 || mem_d !== 8'h00) begin errors++; $display("FAIL reset_a_d: got a=%h d=%h want 00 00", mem_a, mem_d); end
    next_cycle();
    reset = 1'b1;
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
  endtask

  task automatic test_write_read();
    do_reset();
    set_in(1, 0, 8'h10, 8'h5A, 0, 1, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", {r1_gnt, r0_gnt}); end
    checks++; if ({mem_cen, mem_wen, mem_a, mem_d} !== {2'b00, 8'h10, 8'h5A}) begin errors++; $display("FAIL wr_pins: got cen=%b wen=%b a=%h d=%h want 0 0 10 5a", mem_cen, mem_wen, mem_a, mem_d); end
    next_cycle();
    set_in(1, 1, 8'h10, 8'h00, 0, 1, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b want 01", {r1_gnt, r0_gnt}); end
    checks++; if ({r1_rvalid, r0_rvalid} !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid: got %b want 00", {r1_rvalid, r0_rvalid}); end
    checks++; if ({mem_cen, mem_wen, mem_a} !== {2'b01, 8'h10}) begin errors++; $display("FAIL rd_pins: got cen=%b wen=%b a=%h want 0 1 10", mem_cen, mem_wen, mem_a); end
    next_cycle();
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if ({r1_rvalid, r0_rvalid} !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b want 01", {r1_rvalid, r0_rvalid}); end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h want 5a", rdata); end
    checks++; if (mem_cen !== 1'b1) begin errors++; $display("FAIL idle_cen: got %b want 1", mem_cen); end
    next_cycle();
    @(negedge clk);
    checks++; if ({r1_rvalid, r0_rvalid} !== 2'b00 || rdata !== 8'h00) begin errors++; $display("FAIL rd_once: got rv=%b data=%h want 00 00", {r1_rvalid, r0_rvalid}, rdata); end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [10];
    logic       prev;
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    prev = 1'b0;
    do_reset();
    set_in(1, 0, 8'h20, 8'hA0, 0, 1, 8'h00, 8'h00);
    next_cycle();
    set_in(0, 1, 8'h00, 8'h00, 1, 0, 8'h21, 8'hB1);
    next_cycle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, 8'h20, 8'h00, 1, 1, 8'h21, 8'h00);
      @(negedge clk);
      checks++; if ({r1_gnt, r0_gnt} !== exp_g[i]) begin errors++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, {r1_gnt, r0_gnt}, exp_g[i]); end
      if (i > 0) begin
        checks++; if ({r1_rvalid, r0_rvalid} !== (prev ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_tag[%0d]: got %b want %b", i, {r1_rvalid, r0_rvalid}, prev ? 2'b10 : 2'b01); end
        checks++; if (rdata !== (prev ? 8'hB1 : 8'hA0)) begin errors++; $display("FAIL cont_data[%0d]: got %h want %h", i, rdata, prev ? 8'hB1 : 8'hA0); end
      end
      prev = exp_g[i][1];
      next_cycle();
    end
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    next_cycle();
  endtask

  task automatic test_sticky();
    logic [1:0] exp_g [6];
    exp_g = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 8'h00, 8'h00, 1, 1, 8'h01, 8'h00);
      @(negedge clk);
      checks++; if ({r1_gnt, r0_gnt} !== 2'b10) begin errors++; $display("FAIL sticky_solo[%0d]: got %b want 10", i, {r1_gnt, r0_gnt}); end
      next_cycle();
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1, 8'h02, 8'h00, 1, 1, 8'h01, 8'h00);
      @(negedge clk);
      checks++; if ({r1_gnt, r0_gnt} !== exp_g[i]) begin errors++; $display("FAIL sticky_tie[%0d]: got %b want %b", i, {r1_gnt, r0_gnt}, exp_g[i]); end
      next_cycle();
    end
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    next_cycle();
  endtask

  task automatic test_idle();
    logic [1:0] exp_g [5];
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 8'h00, 8'h00, 1, 1, 8'h03, 8'h00);
      @(negedge clk);
      checks++; if ({r1_gnt, r0_gnt} !== 2'b10) begin errors++; $display("FAIL idle_solo[%0d]: got %b want 10", i, {r1_gnt, r0_gnt}); end
      next_cycle();
    end
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt, mem_cen} !== 3'b001) begin errors++; $display("FAIL idle_gap: got gnt=%b cen=%b want 00 1", {r1_gnt, r0_gnt}, mem_cen); end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 8'h04, 8'h00, 1, 1, 8'h03, 8'h00);
      @(negedge clk);
      checks++; if ({r1_gnt, r0_gnt} !== exp_g[i]) begin errors++; $display("FAIL idle_tie[%0d]: got %b want %b", i, {r1_gnt, r0_gnt}, exp_g[i]); end
      next_cycle();
    end
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(0, 1, 8'h00, 8'h00, 1, 1, 8'h21, 8'h00);
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b10) begin errors++; $display("FAIL mid_gnt: got %b want 10", {r1_gnt, r0_gnt}); end
    next_cycle();
    reset = 1'b0;
    set_in(1, 0, 8'h05, 8'h77, 1, 0, 8'h06, 8'h88);
    @(negedge clk);
    checks++; if ({r1_rvalid, r0_rvalid} !== 2'b00 || rdata !== 8'h00) begin errors++; $display("FAIL mid_rvalid: got rv=%b data=%h want 00 00", {r1_rvalid, r0_rvalid}, rdata); end
    checks++; if ({r1_gnt, r0_gnt, mem_cen, mem_wen} !== 4'b0011) begin errors++; $display("FAIL mid_pins: got gnt=%b cen=%b wen=%b want 00 1 1", {r1_gnt, r0_gnt}, mem_cen, mem_wen); end
    next_cycle();
    reset = 1'b1;
    set_in(1, 1, 8'h20, 8'h00, 1, 1, 8'h21, 8'h00);
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin errors++; $display("FAIL mid_first_tie: got %b want 01", {r1_gnt, r0_gnt}); end
    checks++; if ({r1_rvalid, r0_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_after_rvalid: got %b want 00", {r1_rvalid, r0_rvalid}); end
    next_cycle();
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    next_cycle();
  endtask

  task automatic test_cross_port();
    do_reset();
    set_in(0, 1, 8'h00, 8'h00, 1, 0, 8'h00, 8'hFF);
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b10) begin errors++; $display("FAIL cross_wr_gnt: got %b want 10", {r1_gnt, r0_gnt}); end
    next_cycle();
    set_in(1, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin errors++; $display("FAIL cross_rd_gnt: got %b want 01", {r1_gnt, r0_gnt}); end
    next_cycle();
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if ({r1_rvalid, r0_rvalid} !== 2'b01) begin errors++; $display("FAIL cross_rvalid: got %b want 01", {r1_rvalid, r0_rvalid}); end
    checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL cross_data: got %h want ff", rdata); end
    next_cycle();
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
    next_cycle();
    test_reset();
    test_write_read();
    test_contention();
    test_sticky();
    test_idle();
    test_reset_mid();
    test_cross_port();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
